mat_vec_mult_sys: RTL and testbench
===================================

Name: mat_vec_mult_sys

Overview:
Parametrised successor of the 8x8 matrix-vector MAC array. Computes y = A·b for a ROWS x COLS matrix A and a COLS-entry vector b. A and b are held in internal load buffers, streamed through a skewed systolic row of PEs, and the result vector is presented with a valid/ready handshake. It sits between the host load logic and downstream result consumers, and adds signed mode, backpressure, abort and configurable accumulator width.

Parameters:
ROWS, 8, number of matrix rows, PEs and outputs (>=1)
COLS, 8, matrix columns and vector length (>=1)
DATA_WIDTH, 8, width of A and b elements
ACC_WIDTH, 3*DATA_WIDTH, accumulator and output width; exact result needs 2*DATA_WIDTH+$clog2(COLS)
SIGNED, 0, 1 = two's-complement operands and accumulation; 0 = unsigned

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous abort: empties buffers, zeroes accumulators, returns to LOAD
a_wren  in  [ROWS]  per-row element write strobe
a_wdata  in  [ROWS][DATA_WIDTH]  per-row element data
b_wren  in  1  vector element write strobe
b_wdata  in  DATA_WIDTH  vector element data
a_full  out  [ROWS]  row i holds COLS elements
b_full  out  1  vector holds COLS elements
busy  out  1  state is COMPUTE or DONE
res_valid  out  1  out[] holds a final result
res_ready  in  1  consumer accepts the result
out  out  [ROWS][ACC_WIDTH]  result vector, out[i] = sum_k A[i][k]*b[k]

Behaviour:
- Reset: state LOAD; all write pointers 0; all a_full, b_full, busy, res_valid and out = 0.
- Load: in LOAD, a_wren[i] writes a_wdata[i] to A[i][ptr_i] and increments ptr_i. Writes to a full row, or any write outside LOAD, are ignored. b uses the same rules. Loading order: element k is the k-th write.
- FSM LOAD->COMPUTE on the cycle after all a_full and b_full are 1 (registered check).
- COMPUTE: counter t runs 0..ROWS+COLS-2. At cycle t, PE i accumulates A[i][t-i]*b[t-i] when 0 <= t-i < COLS; otherwise it holds. Skew is realised with a b shift chain.
- COMPUTE->DONE after t = ROWS+COLS-2. Latency from entering COMPUTE to res_valid = ROWS+COLS-1 cycles.
- DONE: res_valid = 1; out stable while res_ready = 0. On a cycle with res_valid && res_ready: next cycle state LOAD, buffers emptied, res_valid = 0, accumulators zeroed. out holds its last value until the next COMPUTE starts.
- Arithmetic: product is 2*DATA_WIDTH, sign- or zero-extended per SIGNED to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH.
- clr: highest priority after rst, in any state. Next cycle: LOAD, pointers 0, full flags 0, accumulators and out 0, res_valid 0. Writes in the same cycle as clr are dropped.
- Reset mid-operation: immediate return to the reset values above; no partial result is emitted.
- Writes during DONE for the next matrix are ignored; loading resumes in LOAD.

Optional Feature:
MVM_SATURATE_EN:
- Defined: each accumulate clamps to the ACC_WIDTH range, i.e. [0, 2^ACC_WIDTH-1] unsigned or [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] signed. Once saturated, a PE stays clamped unless an opposite-sign add brings it back in range (checked every step).
- Undefined: modular wrap.

Decomposition:
- Package mvm_pkg: state enum typedef (LOAD, COMPUTE, DONE); helper function for the exact accumulator width; saturation bound constants.
- Sub-module mvm_pe: one MAC with en, clr, signed mode and optional saturation. Instantiated ROWS times.
- Buffers, pointers, skew chain and FSM stay in the top module.

Test Plan:
- Identity A (8x8), b = 1..8 -> out = 1..8; res_valid rises exactly 15 cycles after COMPUTE entry.
- Unsigned, all A and b = 255 -> every out = 520200 (0x07F008).
- SIGNED=1, all A and b = -128 -> out = 131072; A row 0 = -1, b = 1 -> out[0] = -8.
- Hold res_ready = 0 for 5 cycles in DONE -> out and res_valid stable; extra a_wren/b_wren ignored; ready pulse -> LOAD next cycle, full flags 0.
- Assert clr at t = 3 of COMPUTE -> LOAD next cycle, out = 0, res_valid never rises. Repeat with rst -> same, asynchronously.
- ACC_WIDTH = 16, unsigned all 255 -> 520200 mod 65536 = 61448 without MVM_SATURATE_EN, 65535 with it; 9th write to a full row ignored.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and constants for the mat_vec_mult_sys matrix-vector engine.
// Optional build macro MVM_SATURATE_EN selects clamping accumulators instead of modular wrap.
package mvm_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mvm_state_e;

`ifdef MVM_SATURATE_EN
    localparam bit MVM_SAT_EN = 1'b1;
`else
    localparam bit MVM_SAT_EN = 1'b0;
`endif

    // Accumulator width that can never overflow for a COLS-long dot product.
    function automatic int mvm_exact_acc_width(input int data_width, input int cols);
        return 2 * data_width + $clog2(cols);
    endfunction

endpackage

// File: rtl/mvm_pe.sv
// One multiply-accumulate cell of the systolic row; signed or unsigned operands.
// Clamps at the accumulator range when built with MVM_SATURATE_EN, otherwise wraps.
module mvm_pe
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;
    // One guard bit above the wider operand so the raw sum never overflows.
    localparam int EW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = (SIGNED != 0) ? {1'b0, {(ACC_WIDTH-1){1'b1}}}
                                                             : {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = (SIGNED != 0) ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                             : {ACC_WIDTH{1'b0}};
    localparam logic [EW-1:0] SAT_MAX_EXT = EW'(SAT_MAX);
    localparam logic [EW-1:0] SAT_MIN_EXT = {{(EW-ACC_WIDTH){SAT_MIN[ACC_WIDTH-1]}}, SAT_MIN};

    logic [PW-1:0]        prod;
    logic [EW-1:0]        prod_ext;
    logic [EW-1:0]        acc_ext;
    logic [EW-1:0]        sum_ext;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] acc_next;

    always_comb begin
        prod     = '0;
        prod_ext = '0;
        acc_ext  = '0;
        if (SIGNED != 0) begin
            prod     = $signed(a) * $signed(b);
            prod_ext = EW'($signed(prod));
            acc_ext  = EW'($signed(acc_reg));
        end else begin
            prod     = a * b;
            prod_ext = EW'(prod);
            acc_ext  = EW'(acc_reg);
        end
        sum_ext  = prod_ext + acc_ext;
        acc_next = sum_ext[ACC_WIDTH-1:0];
        if (MVM_SAT_EN) begin
            if (SIGNED != 0) begin
                if ($signed(sum_ext) > $signed(SAT_MAX_EXT)) begin
                    acc_next = SAT_MAX;
                end else if ($signed(sum_ext) < $signed(SAT_MIN_EXT)) begin
                    acc_next = SAT_MIN;
                end
            end else if (sum_ext > SAT_MAX_EXT) begin
                acc_next = SAT_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/mat_vec_mult_sys.sv
// y = A*b engine: load buffers, skewed systolic PE row, valid/ready result hand-off.
// Build macro MVM_SATURATE_EN (see mvm_pkg) switches the PEs to saturating accumulation.
module mat_vec_mult_sys
    import mvm_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int SIGNED     = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic [ROWS-1:0]                      a_wren,
    input  logic [ROWS-1:0][DATA_WIDTH-1:0]      a_wdata,
    input  logic                                 b_wren,
    input  logic [DATA_WIDTH-1:0]                b_wdata,
    output logic [ROWS-1:0]                      a_full,
    output logic                                 b_full,
    output logic                                 busy,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [ROWS-1:0][ACC_WIDTH-1:0]       out
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = $clog2(COLS + 1);
    localparam int TW = $clog2(ROWS + COLS);
    localparam logic [PW-1:0] PTR_FULL = PW'(COLS);
    localparam logic [TW-1:0] T_LAST   = TW'(ROWS + COLS - 2);

    mvm_state_e            state_reg, state_next;
    logic [TW-1:0]         t_reg;
    logic                  in_load, in_compute, flush, all_full;
    logic [PW-1:0]         b_ptr_reg;
    logic                  b_we;
    logic [DATA_WIDTH-1:0] b_mem [COLS];
    logic [DATA_WIDTH-1:0] b_tap [ROWS];

    assign in_load    = (state_reg == LOAD);
    assign in_compute = (state_reg == COMPUTE);
    assign busy       = !in_load;
    assign res_valid  = (state_reg == DONE);
    // Abort and result acceptance both empty the buffers and zero the PEs.
    assign flush      = clr || (res_valid && res_ready);
    assign all_full   = (&a_full) && b_full;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (all_full)        state_next = COMPUTE;
            COMPUTE: if (t_reg == T_LAST) state_next = DONE;
            DONE:    if (res_ready)       state_next = LOAD;
            default:                      state_next = LOAD;
        endcase
        if (clr) begin
            state_next = LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= (in_compute && !clr) ? t_reg + 1'b1 : '0;
        end
    end

    assign b_we   = b_wren && in_load && (b_ptr_reg != PTR_FULL) && !clr;
    assign b_full = (b_ptr_reg == PTR_FULL);

    always_ff @(posedge clk) begin
        if (b_we) begin
            b_mem[b_ptr_reg[CW-1:0]] <= b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_ptr_reg <= '0;
        end else if (flush) begin
            b_ptr_reg <= '0;
        end else if (b_we) begin
            b_ptr_reg <= b_ptr_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [DATA_WIDTH-1:0] row_mem [COLS];
            logic [PW-1:0]         ptr_reg;
            logic                  we, en;
            logic [TW-1:0]         col;
            logic [ACC_WIDTH-1:0]  acc, hold_reg;

            assign we        = a_wren[gi] && in_load && (ptr_reg != PTR_FULL) && !clr;
            assign a_full[gi] = (ptr_reg == PTR_FULL);

            always_ff @(posedge clk) begin
                if (we) begin
                    row_mem[ptr_reg[CW-1:0]] <= a_wdata[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr_reg <= '0;
                end else if (flush) begin
                    ptr_reg <= '0;
                end else if (we) begin
                    ptr_reg <= ptr_reg + 1'b1;
                end
            end

            // Row gi sees column t-gi; the b chain delays b by gi cycles to match.
            if (gi == 0) begin : g_head
                assign b_tap[gi] = b_mem[t_reg[CW-1:0]];
            end else begin : g_skew
                logic [DATA_WIDTH-1:0] skew_reg;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        skew_reg <= '0;
                    end else begin
                        skew_reg <= b_tap[gi-1];
                    end
                end
                assign b_tap[gi] = skew_reg;
            end

            assign col = t_reg - TW'(gi);
            assign en  = in_compute && (t_reg >= TW'(gi)) && (col < TW'(COLS));

            mvm_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SIGNED     (SIGNED)
            ) u_pe (
                .clk (clk),
                .rst (rst),
                .clr (flush),
                .en  (en),
                .a   (row_mem[col[CW-1:0]]),
                .b   (b_tap[gi]),
                .acc (acc)
            );

            // Keeps the last result visible after hand-off while the PE restarts from zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_reg <= '0;
                end else if (clr) begin
                    hold_reg <= '0;
                end else if (res_valid) begin
                    hold_reg <= acc;
                end
            end

            assign out[gi] = busy ? acc : hold_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mat_vec_mult_sys.sv
// Directed bench: default unsigned, signed, and 16-bit accumulator instances share one stimulus stream.
module tb_mat_vec_mult_sys;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic [7:0]       a_wren = '0;
    logic [7:0][7:0]  a_wdata = '0;
    logic             b_wren = 1'b0;
    logic [7:0]       b_wdata = '0;
    logic             res_ready = 1'b0;

    logic [7:0]       a_full0, a_full1, a_full2;
    logic             b_full0, b_full1, b_full2;
    logic             busy0, busy1, busy2;
    logic             res_valid0, res_valid1, res_valid2;
    logic [7:0][23:0] out0, out1;
    logic [7:0][15:0] out2;

`ifdef MVM_SATURATE_EN
    localparam logic [63:0] E16_255 = 64'd65535;
    localparam logic [63:0] E16_128 = 64'd65535;
`else
    localparam logic [63:0] E16_255 = 64'd61448;
    localparam logic [63:0] E16_128 = 64'd0;
`endif

    always #5 clk = ~clk;

    mat_vec_mult_sys #(.ROWS(8), .COLS(8), .DATA_WIDTH(8), .ACC_WIDTH(24), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .a_wren(a_wren), .a_wdata(a_wdata),
        .b_wren(b_wren), .b_wdata(b_wdata), .a_full(a_full0), .b_full(b_full0),
        .busy(busy0), .res_valid(res_valid0), .res_ready(res_ready), .out(out0));

    mat_vec_mult_sys #(.ROWS(8), .COLS(8), .DATA_WIDTH(8), .ACC_WIDTH(24), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .a_wren(a_wren), .a_wdata(a_wdata),
        .b_wren(b_wren), .b_wdata(b_wdata), .a_full(a_full1), .b_full(b_full1),
        .busy(busy1), .res_valid(res_valid1), .res_ready(res_ready), .out(out1));

    mat_vec_mult_sys #(.ROWS(8), .COLS(8), .DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .a_wren(a_wren), .a_wdata(a_wdata),
        .b_wren(b_wren), .b_wdata(b_wdata), .a_full(a_full2), .b_full(b_full2),
        .busy(busy2), .res_valid(res_valid2), .res_ready(res_ready), .out(out2));

    int         total = 0;
    int         bad = 0;
    logic [7:0] a_mat [8][8];
    logic [7:0] b_vec [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) a_mat[i][k] = av;
            b_vec[i] = bv;
        end
    endtask

    task automatic load_all();
        for (int k = 0; k < 8; k++) begin
            a_wren = 8'hFF;
            for (int i = 0; i < 8; i++) a_wdata[i] = a_mat[i][k];
            b_wren  = 1'b1;
            b_wdata = b_vec[k];
            step();
        end
        a_wren = '0;
        b_wren = 1'b0;
    endtask

    task automatic wait_result(input string tag, output int lat);
        int n;
        n = 0;
        while (!busy0 && n < 5) begin step(); n++; end
        n = 0;
        while (!res_valid0 && n < 40) begin step(); n++; end
        chk({tag, "_valid"}, 64'({res_valid0, res_valid1, res_valid2}), 64'd7);
        lat = n;
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_hs_valid"}, 64'(res_valid0), 64'd0);
        chk({tag, "_hs_busy"}, 64'(busy0), 64'd0);
    endtask

    initial begin
        int   lat;
        logic seen;

        repeat (3) step();
        chk("rst_busy", 64'({busy0, busy1, busy2}), 64'd0);
        chk("rst_valid", 64'({res_valid0, res_valid1, res_valid2}), 64'd0);
        chk("rst_full", 64'({a_full0, b_full0, a_full2, b_full2}), 64'd0);
        chk("rst_out", 64'(|{out0, out1, out2}), 64'd0);
        rst = 1'b0;
        step();

        // Identity matrix, b = 1..8
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) a_mat[i][k] = (i == k) ? 8'd1 : 8'd0;
            b_vec[i] = 8'(i + 1);
        end
        load_all();
        chk("id_afull", 64'(a_full0), 64'hFF);
        chk("id_bfull", 64'(b_full0), 64'd1);
        chk("id_busy_load", 64'(busy0), 64'd0);
        wait_result("id", lat);
        chk("id_latency", 64'(lat), 64'd15);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("id_out0_%0d", i), 64'(out0[i]), 64'(i + 1));
            chk($sformatf("id_out1_%0d", i), 64'(out1[i]), 64'(i + 1));
            chk($sformatf("id_out2_%0d", i), 64'(out2[i]), 64'(i + 1));
        end

        // Backpressure in DONE with stray writes
        for (int c = 0; c < 5; c++) begin
            a_wren = 8'hFF;
            for (int i = 0; i < 8; i++) a_wdata[i] = 8'h55;
            b_wren  = 1'b1;
            b_wdata = 8'h55;
            step();
            chk($sformatf("bp_valid_%0d", c), 64'(res_valid0), 64'd1);
            chk($sformatf("bp_out3_%0d", c), 64'(out0[3]), 64'd4);
            chk($sformatf("bp_out2_7_%0d", c), 64'(out2[7]), 64'd8);
        end
        handshake("bp");
        a_wren = '0;
        b_wren = 1'b0;
        chk("bp_afull", 64'(a_full0), 64'd0);
        chk("bp_bfull", 64'(b_full0), 64'd0);
        chk("bp_hold", 64'(out0[3]), 64'd4);
        step();
        chk("bp_stay_load", 64'(busy0), 64'd0);

        // All elements 255
        fill(8'hFF, 8'hFF);
        load_all();
        wait_result("ff", lat);
        chk("ff_out0_0", 64'(out0[0]), 64'd520200);
        chk("ff_out0_7", 64'(out0[7]), 64'd520200);
        chk("ff_out1_0", 64'(out1[0]), 64'd8);
        chk("ff_out2_0", 64'(out2[0]), E16_255);
        chk("ff_out2_6", 64'(out2[6]), E16_255);
        handshake("ff");

        // All elements 0x80 (-128 signed)
        fill(8'h80, 8'h80);
        load_all();
        wait_result("m128", lat);
        chk("m128_out0_0", 64'(out0[0]), 64'd131072);
        chk("m128_out1_5", 64'(out1[5]), 64'd131072);
        chk("m128_out2_0", 64'(out2[0]), E16_128);
        handshake("m128");

        // Row 0 = -1 (0xFF), other rows 0, b = 1
        fill(8'h00, 8'h01);
        for (int k = 0; k < 8; k++) a_mat[0][k] = 8'hFF;
        load_all();
        wait_result("neg", lat);
        chk("neg_out0_0", 64'(out0[0]), 64'd2040);
        chk("neg_out1_0", 64'(out1[0]), 64'hFFFFF8);
        chk("neg_out2_0", 64'(out2[0]), 64'd2040);
        chk("neg_out0_1", 64'(out0[1]), 64'd0);
        handshake("neg");

        // Ninth write to a full row is ignored
        a_wren = 8'h80;
        for (int k = 0; k < 9; k++) begin
            a_wdata[7] = (k < 8) ? 8'd1 : 8'd100;
            step();
        end
        a_wren = '0;
        chk("ovf_afull", 64'(a_full0), 64'h80);
        chk("ovf_busy", 64'(busy0), 64'd0);
        for (int k = 0; k < 8; k++) begin
            a_wren = 8'h7F;
            for (int i = 0; i < 7; i++) a_wdata[i] = 8'd1;
            b_wren  = 1'b1;
            b_wdata = 8'd1;
            step();
        end
        a_wren = '0;
        b_wren = 1'b0;
        wait_result("ovf", lat);
        chk("ovf_out0_7", 64'(out0[7]), 64'd8);
        chk("ovf_out0_0", 64'(out0[0]), 64'd8);
        handshake("ovf");

        // clr at t = 3 of COMPUTE
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) a_mat[i][k] = (i == k) ? 8'd1 : 8'd0;
            b_vec[i] = 8'(i + 1);
        end
        load_all();
        step();
        chk("clr_entry_busy", 64'(busy0), 64'd1);
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", 64'(busy0), 64'd0);
        chk("clr_valid", 64'(res_valid0), 64'd0);
        chk("clr_out", 64'(|{out0, out1, out2}), 64'd0);
        chk("clr_full", 64'({a_full0, b_full0}), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step();
            seen |= res_valid0 | res_valid1 | res_valid2;
        end
        chk("clr_no_valid", 64'(seen), 64'd0);

        // Writes in the clr cycle are dropped
        clr    = 1'b1;
        a_wren = 8'hFF;
        b_wren = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        chk("clrw_afull7", 64'(a_full0), 64'd0);
        chk("clrw_bfull7", 64'(b_full0), 64'd0);
        step();
        a_wren = '0;
        b_wren = 1'b0;
        chk("clrw_afull8", 64'(a_full0), 64'hFF);
        chk("clrw_bfull8", 64'(b_full0), 64'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrw_empty", 64'({a_full0, b_full0, busy0}), 64'd0);

        // Asynchronous reset at t = 3 of COMPUTE
        load_all();
        step();
        repeat (3) step();
        chk("rstm_out_before", 64'(out0[0]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstm_busy", 64'({busy0, busy1, busy2}), 64'd0);
        chk("rstm_valid", 64'(res_valid0), 64'd0);
        chk("rstm_out", 64'(|{out0, out1, out2}), 64'd0);
        chk("rstm_full", 64'({a_full0, b_full0}), 64'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step();
            seen |= res_valid0 | res_valid1 | res_valid2;
        end
        chk("rstm_no_valid", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
